// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Pure declarations: no latency, no flow control.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Right-justified byte mask for the access size encoded in funct3[1:0].
  function automatic logic [3:0] access_mask(input logic [1:0] size_code);
    case (size_code)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
    if (store) return (funct3 > F3_W);
    return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane mask, store-data rotation and load extraction/extension for one access.
// Purely combinational; no flow control.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] hold_data,
  output logic [7:0]  lane_mask,
  output logic [31:0] store_lanes,
  output logic [31:0] load_value
);

  logic [5:0]  sh_amt;
  logic [5:0]  sh_inv;
  logic [31:0] hold_rot;

  always_comb begin
    sh_amt = {1'b0, offset, 3'b000};
    sh_inv = 6'd32 - sh_amt;
    // Bits [7:4] are the lanes that spill into the following word.
    lane_mask   = {4'b0000, access_mask(funct3[1:0])} << offset;
    store_lanes = (store_data << sh_amt) | (store_data >> sh_inv);
    hold_rot    = (hold_data >> sh_amt) | (hold_data << sh_inv);
    case (funct3)
      F3_B:    load_value = {{24{hold_rot[7]}}, hold_rot[7:0]};
      F3_H:    load_value = {{16{hold_rot[15]}}, hold_rot[15:0]};
      F3_W:    load_value = hold_rot;
      F3_BU:   load_value = {24'd0, hold_rot[7:0]};
      F3_HU:   load_value = {16'd0, hold_rot[15:0]};
      default: load_value = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: splits word-crossing accesses into two word accesses and extends loads.
// Response 2 cycles after accept (3 when crossing, 1 on illegal funct3); accepts only in IDLE, no response backpressure.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqStore,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspError,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        store_q, store_d;
  logic        err_q, err_d;
  logic [31:0] hold_q, hold_d;

  logic [7:0]  lane_mask;
  logic [31:0] store_lanes;
  logic [31:0] load_value;
  logic [31:0] word_addr;
  logic [3:0]  lanes_now;
  logic [31:0] lane_bits;
  logic        acc;

  lsu_lane_align u_align (
    .offset      (addr_q[1:0]),
    .funct3      (funct3_q),
    .store_data  (wdata_q),
    .hold_data   (hold_q),
    .lane_mask   (lane_mask),
    .store_lanes (store_lanes),
    .load_value  (load_value)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    err_d    = err_q;
    hold_d   = hold_q;

    reqReady       = (state_q == ST_IDLE) && resetN;
    rspValid       = 1'b0;
    rspData        = 32'd0;
    rspError       = 1'b0;
    memAddress     = 32'd0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    memByteEnable  = 4'd0;
    memWriteData   = 32'd0;

    word_addr = {addr_q[31:2], 2'b00};
    lanes_now = 4'd0;
    acc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          addr_d   = reqAddress;
          funct3_d = reqFunct3;
          wdata_d  = reqWriteData;
          store_d  = reqStore;
          err_d    = funct3_illegal(reqStore, reqFunct3);
          state_d  = funct3_illegal(reqStore, reqFunct3) ? ST_RESP : ST_ACC0;
        end
      end
      ST_ACC0: begin
        acc        = 1'b1;
        memAddress = word_addr;
        lanes_now  = lane_mask[3:0];
        state_d    = (|lane_mask[7:4]) ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        acc        = 1'b1;
        memAddress = word_addr + 32'd4;
        lanes_now  = lane_mask[7:4];
        state_d    = ST_RESP;
      end
      default: begin
        rspValid = 1'b1;
        rspError = err_q;
        rspData  = (store_q || err_q) ? 32'd0 : load_value;
        state_d  = ST_IDLE;
      end
    endcase

    memByteEnable  = lanes_now;
    memReadEnable  = acc && !store_q;
    memWriteEnable = acc && store_q;
    memWriteData   = (acc && store_q) ? store_lanes : 32'd0;

    // Bytes are kept on their memory lanes; the aligner rotates them down at response time.
    lane_bits = {{8{lanes_now[3]}}, {8{lanes_now[2]}}, {8{lanes_now[1]}}, {8{lanes_now[0]}}};
    if (acc && !store_q) begin
      hold_d = (hold_q & ~lane_bits) | (memReadData & lane_bits);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetN  input  1  asynchronous active-low reset.
REQ-004 reqValid  input  1  pipeline presents a memory request.
REQ-005 reqReady  output  1  LSU can accept a request; high only in IDLE.
REQ-006 reqStore  input  1  1 = store, 0 = load.
REQ-007 reqFunct3  input  3  0 = LB/SB, 1 = LH/SH, 2 = LW/SW, 4 = LBU, 5 = LHU.
REQ-008 reqAddress  input  32  byte address.
REQ-009 reqWriteData  input  32  store data, right-justified.
REQ-010 rspValid  output  1  one-cycle response pulse; no backpressure.
REQ-011 rspData  output  32  extended load data; 0 for stores and errors.
REQ-012 rspError  output  1  qualified by rspValid; illegal funct3.
REQ-013 memAddress  output  32  word-aligned address; bits [1:0] always 0.
REQ-014 memReadEnable  output  1  word read; memReadData is combinational.
REQ-015 memWriteEnable  output  1  word write, committed by memory on the next rising edge.
REQ-016 memByteEnable  output  4  lane mask; bit i = byte i, little-endian.
REQ-017 memWriteData  output  32  lane-positioned store data.
REQ-018 memReadData  input  32  read word, valid in the same cycle as memReadEnable.

Function
REQ-019 SHALL implement the FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
REQ-020 SHALL accept a request on a rising edge when reqValid && reqReady, and register the address, funct3, data and direction.
REQ-021 SHALL enter ACC1 only when the access crosses a word boundary: addr[1:0] + size > 4, with size 1/2/4 bytes.
REQ-022 In ACC0, SHALL drive memAddress = {addr[31:2], 2'b00} and the lanes addr[1:0] through min(3, addr[1:0] + size - 1).
REQ-023 In ACC1, SHALL drive memAddress = ACC0 address + 4 (modulo 2^32; 0xFFFFFFFC wraps to 0x00000000) and the remaining lanes from lane 0.
REQ-024 Memory enables SHALL be high only in ACC0/ACC1; in IDLE/RESP, memAddress, memByteEnable and memWriteData SHALL be 0.
REQ-025 Load bytes SHALL be captured from memReadData at the end of each ACC state into a 32-bit holding register.
REQ-026 Loads SHALL sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-027 Store data SHALL be rotated left by 8*addr[1:0] bits so that each byte lands on its enabled lane.
REQ-028 rspValid SHALL be high for exactly the RESP cycle.
REQ-029 Latency from accept edge N: rspValid in cycle N+2 for a non-crossing access, N+3 for a crossing access.
REQ-030 Illegal funct3 (load 3/6/7; store >= 3) SHALL go IDLE -> RESP directly, with rspError = 1, no memory enable, and rspValid in cycle N+1.
REQ-031 reqValid while not in IDLE SHALL be ignored, with reqReady = 0.
REQ-032 Requests held across RESP SHALL be accepted on the first IDLE edge; back-to-back throughput is 1 request per 3 cycles when no word boundary is crossed.

Reset
REQ-033 On resetN = 0, SHALL immediately enter IDLE.
REQ-034 During reset, every output SHALL be 0 except reqReady, which SHALL be 1 once reset is released.
REQ-035 Reset asserted in ACC0/ACC1 SHALL abort the access: enables drop asynchronously, the access produces no response, and any half-completed split store is not retried.

Structure
REQ-036 lsu_pkg SHALL hold the state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-037 The combinational sub-module lsu_lane_align SHALL compute lane masks, store rotation and load extraction/extension.

Verification
REQ-038 mem word 4 = 0xAABBCCDD; LB at addr 17 -> rspData 0xFFFFFFCC, rspValid at N+2, one read at memAddress 16.
REQ-039 LHU at addr 18 -> rspData 0x0000AABB; LH at addr 18 -> 0xFFFFAABB.
REQ-040 Word 5 = 0x11223344; LW at addr 19 -> reads at 16 then 20, rspData 0x223344AA, rspValid at N+3.
REQ-041 SH 0xABCD at addr 3 -> write addr 0, BE 1000, byte3 = 0xCD; then write addr 4, BE 0001, byte0 = 0xAB; other bytes unchanged.
REQ-042 Load with funct3 = 3 -> rspValid at N+1, rspError = 1, rspData = 0, no memory enable.
REQ-043 Reset pulsed during ACC1 of a crossing SW, then SB 0x5A at addr 0 -> no rspValid for the aborted store; the SB completes normally with BE 0001.
